bfp_converter_ctrl: RTL and testbench

Stream controller that sequences the 32-lane FP-to-BFP converter pipeline. Accepts a programmed number of FP vectors over a valid/ready input, issues them into the non-stallable fixed-latency converter, and tracks each issue with a valid/last tag shift register. Captures converter results into an output FIFO, using credit-based issue so no result is lost under backpressure. Sits between the activation buffer read path and the systolic array's BFP input loader.

---
 rtl/bfp_converter_ctrl_if.sv | 30 +++
 rtl/bfp_converter_ctrl.sv | 146 ++++++++++++++
 tb/tb_bfp_converter_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bfp_converter_ctrl_if.sv
// Stream-side bundle of the FP-to-BFP converter controller: block control,
// FP vector input handshake and BFP vector output handshake.
interface bfp_converter_ctrl_if #(
  parameter int SYST_ARRAY_WIDTH         = 32,
  parameter int QUNATIZED_MANTISSA_WIDTH = 7,
  parameter int EXPONENT_WIDTH           = 8
);
  logic                                                                    start;
  logic [15:0]                                                             num_vectors;
  logic                                                                    in_valid;
  logic                                                                    in_ready;
  logic [SYST_ARRAY_WIDTH*(QUNATIZED_MANTISSA_WIDTH+EXPONENT_WIDTH)-1:0]   in_data;
  logic                                                                    out_valid;
  logic                                                                    out_ready;
  logic [SYST_ARRAY_WIDTH*QUNATIZED_MANTISSA_WIDTH-1:0]                    out_mant;
  logic [EXPONENT_WIDTH-1:0]                                               out_exp;
  logic                                                                    out_last;
  logic                                                                    busy;
  logic                                                                    done;

  modport master (
    output start, num_vectors, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_last, busy, done
  );

  modport slave (
    input  start, num_vectors, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_last, busy, done
  );
endinterface

// File: rtl/bfp_converter_ctrl.sv
// Sequences FP vectors through the fixed-latency FP-to-BFP converter and
// buffers its results in a credit-protected output FIFO.
module bfp_converter_ctrl #(
  parameter int SYST_ARRAY_WIDTH         = 32,
  parameter int QUNATIZED_MANTISSA_WIDTH = 7,
  parameter int EXPONENT_WIDTH           = 8,
  parameter int CONV_LATENCY             = 7,
  parameter int FIFO_DEPTH               = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  bfp_converter_ctrl_if.slave                        io_bus,
  output logic [SYST_ARRAY_WIDTH*(QUNATIZED_MANTISSA_WIDTH+EXPONENT_WIDTH)-1:0] o_conv_data,
  input  logic [SYST_ARRAY_WIDTH*QUNATIZED_MANTISSA_WIDTH-1:0]                  i_conv_mant,
  input  logic [EXPONENT_WIDTH-1:0]                                             i_conv_exp
);
  localparam int MW    = SYST_ARRAY_WIDTH * QUNATIZED_MANTISSA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + CONV_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [15:0]               r_num_vec;
  logic [15:0]               r_acc_cnt;
  logic [CONV_LATENCY-1:0]   r_tag_valid;
  logic [CONV_LATENCY-1:0]   r_tag_last;
  logic [CNT_W-1:0]          r_inflight;
  logic [CNT_W-1:0]          r_fifo_count;
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic                      r_done;

  logic [MW-1:0]             r_mem_mant [FIFO_DEPTH];
  logic [EXPONENT_WIDTH-1:0] r_mem_exp  [FIFO_DEPTH];
  logic                      r_mem_last [FIFO_DEPTH];

  logic w_credit_ok;
  logic w_in_ready;
  logic w_issue;
  logic w_last_issue;
  logic w_push;
  logic w_pop;
  logic w_fifo_empty;
  logic w_start;
  logic w_drain_exit;

  // Credit counts both results still in the converter and results parked in
  // the FIFO, so every issued vector is guaranteed a FIFO slot on arrival.
  assign w_credit_ok  = (r_inflight + r_fifo_count) < CNT_W'(FIFO_DEPTH);
  assign w_in_ready   = (r_state == RUN) && w_credit_ok;
  assign w_issue      = io_bus.in_valid && w_in_ready;
  assign w_last_issue = (r_acc_cnt == r_num_vec - 16'd1);
  assign w_push       = r_tag_valid[CONV_LATENCY-1];
  assign w_fifo_empty = (r_fifo_count == '0);
  assign w_pop        = !w_fifo_empty && io_bus.out_ready;
  assign w_start      = io_bus.start && (r_state == IDLE);
  // Leave DRAIN on the edge that removes the final entry so done lands one cycle after the last pop.
  assign w_drain_exit = (r_inflight == '0) &&
                        (w_fifo_empty || ((r_fifo_count == CNT_W'(1)) && w_pop));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (io_bus.start) w_state_next = (io_bus.num_vectors == 16'd0) ? DRAIN : RUN;
      RUN:     if (w_issue && w_last_issue) w_state_next = DRAIN;
      DRAIN:   if (w_drain_exit) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_done       <= 1'b0;
      r_num_vec    <= '0;
      r_acc_cnt    <= '0;
      r_inflight   <= '0;
      r_fifo_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == DRAIN) && w_drain_exit;
      if (w_start) begin
        r_num_vec <= io_bus.num_vectors;
        r_acc_cnt <= '0;
      end else if (w_issue) begin
        r_acc_cnt <= r_acc_cnt + 16'd1;
      end
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Tag pipeline mirrors the converter latency; stage 0 captures the issue.
  generate
    for (genvar gi = 0; gi < CONV_LATENCY; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag_valid[gi] <= 1'b0;
          r_tag_last[gi]  <= 1'b0;
        end else if (gi == 0) begin
          r_tag_valid[gi] <= w_issue;
          r_tag_last[gi]  <= w_issue && w_last_issue;
        end else begin
          r_tag_valid[gi] <= r_tag_valid[(gi == 0) ? 0 : gi-1];
          r_tag_last[gi]  <= r_tag_last[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_mant[r_wr_ptr] <= i_conv_mant;
      r_mem_exp[r_wr_ptr]  <= i_conv_exp;
      r_mem_last[r_wr_ptr] <= r_tag_last[CONV_LATENCY-1];
    end
  end

  assign o_conv_data      = w_issue ? io_bus.in_data : '0;
  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = !w_fifo_empty;
  assign io_bus.out_mant  = w_fifo_empty ? '0   : r_mem_mant[r_rd_ptr];
  assign io_bus.out_exp   = w_fifo_empty ? '0   : r_mem_exp[r_rd_ptr];
  assign io_bus.out_last  = w_fifo_empty ? 1'b0 : r_mem_last[r_rd_ptr];
  assign io_bus.busy      = (r_state != IDLE);
  assign io_bus.done      = r_done;

`ifndef SYNTHESIS
  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_fifo_count == CNT_W'(FIFO_DEPTH))));
`endif
endmodule

// File: tb/tb_bfp_converter_ctrl.sv
// Scoreboard bench: a behavioural fixed-latency converter feeds the DUT while
// directed blocks push expected results and a monitor pops them on each output.
module tb_bfp_converter_ctrl;
  localparam int SAW = 32;
  localparam int M   = 7;
  localparam int E   = 8;
  localparam int L   = 7;
  localparam int D   = 16;
  localparam int LW  = SAW * (M + E);
  localparam int MW  = SAW * M;

  typedef struct packed {
    logic [MW-1:0] mant;
    logic [E-1:0]  expo;
    logic          lst;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bfp_converter_ctrl_if #(.SYST_ARRAY_WIDTH(SAW), .QUNATIZED_MANTISSA_WIDTH(M),
                          .EXPONENT_WIDTH(E)) bif ();
  logic [LW-1:0] conv_data;
  logic [MW-1:0] conv_mant;
  logic [E-1:0]  conv_exp;

  bfp_converter_ctrl #(.SYST_ARRAY_WIDTH(SAW), .QUNATIZED_MANTISSA_WIDTH(M),
                       .EXPONENT_WIDTH(E), .CONV_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_bus      (bif),
    .o_conv_data (conv_data),
    .i_conv_mant (conv_mant),
    .i_conv_exp  (conv_exp)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_issued = 0, first_issue_cyc = 0, last_issue_cyc = 0;
  int   n_pop = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  int   n_done = 0, done_cyc = 0;
  logic done_busy = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural converter: shared exponent is the lane max, mantissas shifted right to align.
  function automatic logic [E-1:0] f_exp(input logic [LW-1:0] d);
    logic [E-1:0] mx = '0;
    for (int i = 0; i < SAW; i++)
      if (d[i*(M+E)+M +: E] > mx) mx = d[i*(M+E)+M +: E];
    return mx;
  endfunction

  function automatic logic [MW-1:0] f_mant(input logic [LW-1:0] d);
    logic [MW-1:0] r;
    logic [E-1:0]  mx = f_exp(d);
    for (int i = 0; i < SAW; i++)
      r[i*M +: M] = d[i*(M+E) +: M] >> (mx - d[i*(M+E)+M +: E]);
    return r;
  endfunction

  logic [MW-1:0] pm [L];
  logic [E-1:0]  pe [L];
  always @(posedge clk) begin
    pm[0] <= f_mant(conv_data);
    pe[0] <= f_exp(conv_data);
    for (int s = 1; s < L; s++) begin
      pm[s] <= pm[s-1];
      pe[s] <= pe[s-1];
    end
  end
  assign conv_mant = pm[L-1];
  assign conv_exp  = pe[L-1];

  // Vector k: lane i exponent = base(k) + i%4, mantissa has its top bit set.
  function automatic logic [E-1:0] base_exp(input int k);
    return 8'(16 + (k * 5) % 200);
  endfunction

  function automatic logic [M-1:0] lane_mant(input int k, input int i);
    return 7'h40 | 7'((k * 3 + i) & 63);
  endfunction

  function automatic logic [LW-1:0] mk_vec(input int k);
    logic [LW-1:0] d;
    for (int i = 0; i < SAW; i++) begin
      d[i*(M+E) +: M]   = lane_mant(k, i);
      d[i*(M+E)+M +: E] = base_exp(k) + 8'(i % 4);
    end
    return d;
  endfunction

  // Hand-derived result: max exponent is base+3, lane i is shifted by 3 - i%4.
  function automatic exp_t exp_entry(input int k, input bit lst);
    exp_t r;
    for (int i = 0; i < SAW; i++)
      r.mant[i*M +: M] = lane_mant(k, i) >> (3 - (i % 4));
    r.expo = base_exp(k) + 8'd3;
    r.lst  = lst;
    return r;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.done) begin
        n_done++;
        done_cyc  = cyc;
        done_busy = bif.busy;
      end
      if (bif.out_valid && q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid cycle=%0d", cyc);
      end else if (bif.out_valid && bif.out_ready) begin
        mon_e = q.pop_front();
        checks++;
        if (bif.out_mant !== mon_e.mant || bif.out_exp !== mon_e.expo || bif.out_last !== mon_e.lst) begin
          failures++;
          $display("FAIL out_data cycle=%0d got m=%h e=%h l=%b expected m=%h e=%h l=%b",
                   cyc, bif.out_mant, bif.out_exp, bif.out_last, mon_e.mant, mon_e.expo, mon_e.lst);
        end else begin
          $display("pop  cycle=%0d exp=%0d last=%b", cyc, bif.out_exp, bif.out_last);
        end
        if (n_pop == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        n_pop++;
      end
    end
  end

  task automatic start_blk(input int nv);
    bif.start       = 1'b1;
    bif.num_vectors = 16'(nv);
    @(posedge clk); #1;
    bif.start = 1'b0;
  endtask

  task automatic send(input int k, input bit lst);
    bit ok = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_data  = mk_vec(k);
    for (int w = 0; w < 300 && !ok; w++) begin
      @(negedge clk);
      if (bif.in_ready) begin
        q.push_back(exp_entry(k, lst));
        if (n_issued == 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
        n_issued++;
        ok = 1'b1;
        $display("send cycle=%0d k=%0d last=%b", cyc, k, lst);
      end
    end
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    bif.in_data  = '0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_done(input int n0, input bit check_timing);
    for (int w = 0; w < 500 && n_done == n0; w++) @(negedge clk);
    chk("done_count", n_done - n0, 1);
    chk("busy_at_done", longint'(done_busy), 0);
    if (check_timing) chk("done_after_last_pop", done_cyc - last_pop_cyc, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    int seen;
    bif.start = 1'b0; bif.num_vectors = '0; bif.in_valid = 1'b0;
    bif.in_data = '0; bif.out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready",  longint'(bif.in_ready), 0);
    chk("rst_out_valid", longint'(bif.out_valid), 0);
    chk("rst_busy",      longint'(bif.busy), 0);
    chk("rst_done",      longint'(bif.done), 0);
    chk("rst_out_last",  longint'(bif.out_last), 0);
    chk("rst_out_exp",   longint'(bif.out_exp), 0);
    chk("rst_conv_zero", longint'(conv_data == '0), 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single vector: latency and done timing
    bif.out_ready = 1'b1;
    n0 = n_done; n_pop = 0; n_issued = 0;
    start_blk(1);
    chk("busy_after_start", longint'(bif.busy), 1);
    send(0, 1'b1);
    do @(negedge clk); while (cyc < last_issue_cyc + L);
    chk("out_valid_before_latency", longint'(bif.out_valid), 0);
    @(negedge clk);
    chk("out_valid_at_latency", longint'(bif.out_valid), 1);
    chk("out_last_single", longint'(bif.out_last), 1);
    chk("out_exp_is_max", longint'(bif.out_exp), longint'(base_exp(0) + 8'd3));
    wait_done(n0, 1'b1);

    // 20 vectors at full throughput
    n0 = n_done; n_pop = 0; n_issued = 0;
    start_blk(20);
    for (int k = 1; k <= 20; k++) send(k, k == 20);
    chk("issue_consecutive", last_issue_cyc - first_issue_cyc, 19);
    wait_done(n0, 1'b1);
    chk("stream_pop_count", n_pop, 20);
    chk("stream_no_gaps", last_pop_cyc - first_pop_cyc, 19);

    // Backpressure: credits stop issue at FIFO_DEPTH
    bif.out_ready = 1'b0;
    n0 = n_done; n_pop = 0; n_issued = 0;
    start_blk(20);
    fork
      for (int k = 30; k < 50; k++) send(k, k == 49);
      begin
        repeat (40) @(negedge clk);
        chk("credit_accepted", n_issued, D);
        chk("credit_in_ready_low", longint'(bif.in_ready), 0);
        @(posedge clk); #1;
        bif.out_ready = 1'b1;
      end
    join
    wait_done(n0, 1'b1);
    chk("credit_pop_count", n_pop, 20);

    // Empty block
    n0 = n_done; seen = 0;
    start_blk(0);
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bif.in_ready) seen++;
    end
    chk("empty_no_in_ready", seen, 0);
    chk("empty_done_once", n_done - n0, 1);
    chk("empty_busy_low", longint'(bif.busy), 0);
    @(posedge clk); #1;

    // Reset with results split between converter and FIFO
    bif.out_ready = 1'b0;
    start_blk(10);
    for (int k = 60; k < 65; k++) send(k, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk("pre_reset_out_valid", longint'(bif.out_valid), 1);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", longint'(bif.out_valid), 0);
    chk("mid_rst_out_exp",   longint'(bif.out_exp), 0);
    chk("mid_rst_out_mant",  longint'(bif.out_mant == '0), 1);
    chk("mid_rst_busy",      longint'(bif.busy), 0);
    chk("mid_rst_in_ready",  longint'(bif.in_ready), 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bif.out_ready = 1'b1;
    seen = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bif.out_valid) seen++;
    end
    chk("post_rst_no_out_valid", seen, 0);
    @(posedge clk); #1;
    n0 = n_done; n_pop = 0;
    start_blk(3);
    for (int k = 70; k < 73; k++) send(k, k == 72);
    wait_done(n0, 1'b1);
    chk("post_rst_pop_count", n_pop, 3);

    // start during RUN is ignored
    n0 = n_done; n_pop = 0;
    start_blk(4);
    send(80, 1'b0);
    send(81, 1'b0);
    start_blk(9);
    send(82, 1'b0);
    send(83, 1'b1);
    wait_done(n0, 1'b1);
    chk("restart_pop_count", n_pop, 4);
    repeat (3) @(posedge clk); #1;
    chk("restart_idle_in_ready", longint'(bif.in_ready), 0);
    chk("restart_idle_busy", longint'(bif.busy), 0);
    chk("queue_empty_at_end", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
